// File: rtl/mole_sequencer_if.sv
// mole_sequencer_if: game-control and mole-load signals between sequencer and score tracker
interface mole_sequencer_if;
    logic       gamestart;
    logic       molehit;
    logic       enable;
    logic [7:0] input_pos;
    logic       gameend;
    logic [7:0] round_cnt;

    modport master (
        input  gamestart, molehit,
        output enable, input_pos, gameend, round_cnt
    );

    modport slave (
        output gamestart, molehit,
        input  enable, input_pos, gameend, round_cnt
    );
endinterface

// File: rtl/mole_sequencer.sv
// mole_sequencer: round sequencer issuing one-hot mole positions, load/clear strobes and game end
module mole_sequencer #(
    parameter int unsigned ON_TICKS   = 100000000,
    parameter int unsigned OFF_TICKS  = 25000000,
    parameter int unsigned NUM_ROUNDS = 30,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic             CLK100MHZ,
    input logic             reset,
    mole_sequencer_if.master bus
);
    localparam int unsigned MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW = $clog2(MAX_TICKS);

    typedef enum logic [2:0] {IDLE, LOAD, SHOW, GAP, DONE} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [15:0]   lfsr;
    logic          en, en_nxt;
    logic [7:0]    pos, pos_nxt;
    logic          over, over_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic [2:0]    prev_idx, prev_idx_nxt;
    logic          prev_valid, prev_valid_nxt;
    logic          load;
    logic [2:0]    cand, pick;

    assign cand = lfsr[2:0];
    assign pick = (prev_valid && cand == prev_idx) ? cand + 3'd1 : cand;

    assign bus.enable    = en;
    assign bus.input_pos = pos;
    assign bus.gameend   = over;
    assign bus.round_cnt = cnt;

    // Register state, timer, outputs and mole history; the LFSR free-runs even when idle
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            lfsr       <= LFSR_SEED;
            en         <= 1'b0;
            pos        <= '0;
            over       <= 1'b0;
            cnt        <= '0;
            prev_idx   <= '0;
            prev_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            en         <= en_nxt;
            pos        <= pos_nxt;
            over       <= over_nxt;
            cnt        <= cnt_nxt;
            prev_idx   <= prev_idx_nxt;
            prev_valid <= prev_valid_nxt;
        end
    end

    // Next state and next registered outputs; a low gamestart aborts to IDLE from anywhere
    always_comb begin
        state_nxt      = state;
        timer_nxt      = (timer == '0) ? '0 : timer - TW'(1);
        en_nxt         = 1'b0;
        pos_nxt        = pos;
        over_nxt       = 1'b0;
        cnt_nxt        = cnt;
        prev_idx_nxt   = prev_idx;
        prev_valid_nxt = prev_valid;
        load           = 1'b0;
        case (state)
            IDLE: load = 1'b1;
            LOAD: begin
                state_nxt = SHOW;
                timer_nxt = TW'(ON_TICKS - 1);
            end
            SHOW: if (bus.molehit || timer == '0) begin
                state_nxt = GAP;
                en_nxt    = 1'b1;
                pos_nxt   = '0;
                timer_nxt = TW'(OFF_TICKS - 1);
            end
            GAP: if (timer == '0) begin
                if (cnt == 8'(NUM_ROUNDS)) begin
                    state_nxt = DONE;
                    over_nxt  = 1'b1;
                end else begin
                    load = 1'b1;
                end
            end
            DONE: over_nxt = 1'b1;
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            state_nxt      = LOAD;
            en_nxt         = 1'b1;
            pos_nxt        = 8'd1 << pick;
            cnt_nxt        = cnt + 8'd1;
            prev_idx_nxt   = pick;
            prev_valid_nxt = 1'b1;
        end
        if (!bus.gamestart) begin
            state_nxt      = IDLE;
            timer_nxt      = '0;
            en_nxt         = 1'b0;
            pos_nxt        = '0;
            over_nxt       = 1'b0;
            cnt_nxt        = '0;
            prev_valid_nxt = 1'b0;
        end
    end
endmodule

// File: tb/tb_mole_sequencer.sv
// tb_mole_sequencer: directed and randomized checks of mole_sequencer against a duration-based model
module tb_mole_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mole_sequencer_if bus_a();
    mole_sequencer_if bus_b();

    mole_sequencer #(.ON_TICKS(10), .OFF_TICKS(4), .NUM_ROUNDS(3), .LFSR_SEED(16'hACE1)) dut_a (
        .CLK100MHZ(clk), .reset(rst), .bus(bus_a));
    mole_sequencer #(.ON_TICKS(2), .OFF_TICKS(2), .NUM_ROUNDS(255), .LFSR_SEED(16'h1D2B)) dut_b (
        .CLK100MHZ(clk), .reset(rst), .bus(bus_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phases measured in visible cycles (mole = ON+1 cycles unless hit, gap = OFF cycles)
    localparam int M_IDLE = 0, M_MOLE = 1, M_GAP = 2, M_OVER = 3;
    int          m_on[2]   = '{10, 2};
    int          m_off[2]  = '{4, 2};
    int          m_n[2]    = '{3, 255};
    logic [15:0] m_seed[2] = '{16'hACE1, 16'h1D2B};
    logic [15:0] m_lfsr[2];
    int          m_mode[2], m_age[2], m_cnt[2], m_prev[2];
    logic [7:0]  m_pos[2];
    logic        m_en[2], m_end[2];
    int          wrap_seen[2] = '{0, 0};
    bit          started = 1'b0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic model_reset(input int i);
        m_lfsr[i] = m_seed[i];
        m_mode[i] = M_IDLE; m_age[i] = 0; m_cnt[i] = 0; m_prev[i] = -1;
        m_pos[i] = '0; m_en[i] = 1'b0; m_end[i] = 1'b0;
    endtask

    task automatic model_step(input int i, input logic gs, input logic mh);
        logic [15:0] l;
        int c;
        bit start;
        l = m_lfsr[i];
        m_lfsr[i] = lfsr_next(l);
        m_en[i] = 1'b0;
        start = 1'b0;
        if (!gs) begin
            m_mode[i] = M_IDLE; m_pos[i] = '0; m_cnt[i] = 0; m_prev[i] = -1; m_end[i] = 1'b0;
            return;
        end
        case (m_mode[i])
            M_IDLE: start = 1'b1;
            M_MOLE: begin
                if ((m_age[i] >= 1 && mh) || m_age[i] == m_on[i]) begin
                    m_mode[i] = M_GAP; m_age[i] = 0; m_en[i] = 1'b1; m_pos[i] = '0;
                end else m_age[i]++;
            end
            M_GAP: begin
                if (m_age[i] == m_off[i] - 1) begin
                    if (m_cnt[i] == m_n[i]) begin m_mode[i] = M_OVER; m_end[i] = 1'b1; end
                    else start = 1'b1;
                end else m_age[i]++;
            end
            default: ;
        endcase
        if (start) begin
            c = int'(l[2:0]);
            if (c == m_prev[i]) begin
                if (c == 7) wrap_seen[i]++;
                c = (c + 1) % 8;
            end
            m_pos[i] = 8'd1 << c;
            m_prev[i] = c;
            m_cnt[i]++;
            m_en[i] = 1'b1;
            m_mode[i] = M_MOLE;
            m_age[i] = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            started = 1'b1;
            model_reset(0);
            model_reset(1);
        end else if (started) begin
            model_step(0, bus_a.gamestart, bus_a.molehit);
            model_step(1, bus_b.gamestart, bus_b.molehit);
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("a_cycle", {14'd0, bus_a.enable, bus_a.gameend, bus_a.input_pos, bus_a.round_cnt},
                  {14'd0, m_en[0], m_end[0], m_pos[0], 8'(m_cnt[0])});
            check("b_cycle", {14'd0, bus_b.enable, bus_b.gameend, bus_b.input_pos, bus_b.round_cnt},
                  {14'd0, m_en[1], m_end[1], m_pos[1], 8'(m_cnt[1])});
        end
    end

    task automatic run_a;
        int en_n, end_at, vis, gap, bad, load_k;
        bit found;
        en_n = 0; end_at = -1; vis = 0; gap = 0;
        for (int k = 0; k < 200 && end_at < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (bus_a.enable) en_n++;
            if (bus_a.gameend) end_at = k;
            if (k < 15) begin
                if (bus_a.input_pos != 0) vis++;
                else gap++;
            end
        end
        check("a_visible_cycles", vis, 11);
        check("a_gap_cycles", gap, 4);
        check("a_enable_pulses", en_n, 6);
        check("a_gameend_cycle", end_at, 45);
        check("a_final_rounds", bus_a.round_cnt, 3);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_a.enable || !bus_a.gameend) bad++;
        end
        check("a_done_hold", bad, 0);
        bus_a.gamestart = 1'b0;
        @(negedge clk);
        check("a_done_release", {bus_a.gameend, bus_a.round_cnt}, 9'd0);

        bus_a.gamestart = 1'b1;
        @(negedge clk);
        load_k = 0; end_at = -1;
        for (int k = 0; k < 100 && end_at < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (bus_a.enable && bus_a.input_pos != 0) load_k = k;
            if (k == load_k + 4) check("a_hit_clear", {bus_a.enable, bus_a.input_pos}, 9'h100);
            if (bus_a.gameend) end_at = k;
            bus_a.molehit = (k == load_k + 3);
        end
        bus_a.molehit = 1'b0;
        check("a_hit_end_cycle", end_at, 24);
        check("a_hit_rounds", bus_a.round_cnt, 3);
        bus_a.gamestart = 1'b0;
        @(negedge clk);

        bus_a.gamestart = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            found = bus_a.round_cnt == 2 && bus_a.input_pos != 0 && !bus_a.enable;
        end
        check("a_reach_round2", found, 1);
        repeat (3) @(negedge clk);
        bus_a.gamestart = 1'b0;
        @(negedge clk);
        check("a_abort", {bus_a.enable, bus_a.gameend, bus_a.input_pos, bus_a.round_cnt}, 18'd0);
        bus_a.gamestart = 1'b1;
        @(negedge clk);
        check("a_restart", {bus_a.enable, bus_a.round_cnt}, 9'h101);
        bus_a.gamestart = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_b;
        int loads, idle_wait, done_wait;
        logic [7:0] last_pos;
        loads = 0; last_pos = '0;
        idle_wait = $urandom_range(0, 7);
        done_wait = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 80000 && loads < 10000; cyc++) begin
            @(negedge clk);
            if (bus_b.enable && bus_b.input_pos != 0) begin
                check("b_onehot", $onehot(bus_b.input_pos), 1);
                if (last_pos != 0) check("b_differ", bus_b.input_pos != last_pos, 1);
                last_pos = bus_b.input_pos;
                loads++;
            end
            if (!bus_b.gamestart) begin
                if (idle_wait == 0) bus_b.gamestart = 1'b1;
                else idle_wait--;
            end else if (bus_b.gameend) begin
                if (done_wait == 0) begin
                    bus_b.gamestart = 1'b0;
                    last_pos = '0;
                    idle_wait = $urandom_range(0, 7);
                    done_wait = $urandom_range(0, 3);
                end else done_wait--;
            end else if ($urandom_range(0, 1999) == 0) begin
                bus_b.gamestart = 1'b0;
                last_pos = '0;
                idle_wait = $urandom_range(0, 7);
            end
            bus_b.molehit = ($urandom_range(0, 1) == 0);
        end
        check("b_rounds_done", loads >= 10000, 1);
        check("b_wrap7_seen", wrap_seen[1] > 0, 1);
    endtask

    initial begin
        bus_a.gamestart = 1'b1; bus_a.molehit = 1'b0;
        bus_b.gamestart = 1'b0; bus_b.molehit = 1'b0;
        rst = 1'b1;
        check("model_lfsr_step", lfsr_next(16'hACE1), 16'h59C3);
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {bus_a.enable, bus_a.gameend, bus_a.input_pos, bus_a.round_cnt}, 18'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_load", {bus_a.enable, bus_a.input_pos, bus_a.round_cnt}, {1'b1, 8'h02, 8'd1});
        fork
            run_a();
            run_b();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
